rfid_spi_arbiter: RTL and testbench
===================================

Name: rfid_spi_arbiter

Overview:
- Transaction-level controller placed in front of the SPI byte engine. It shares that engine between NREQ requesters, for example the Wishbone SPI bridge and the autonomous card-poll engine of the bike-rack reader.
- Each request is one reader-chip register access: a read or write of a 6-bit register address.
- The block arbitrates round-robin, formats the chip address byte, drives the engine handshake (init/done) and returns the result to the granted requester.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 1024, clk cycles to wait for spi_done before aborting. Used only with SPI_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- req_rw  in  NREQ  1 = read, 0 = write.
- req_addr  in  6*NREQ  register address; requester i uses bits [6i+5:6i].
- req_wdata  in  8*NREQ  write data; requester i uses bits [8i+7:8i].
- ack  out  NREQ  one-cycle completion pulse, one-hot.
- rdata  out  8  read result, valid while ack is high.
- err  out  1  timeout flag, valid while ack is high.
- busy  out  1  high in every state except IDLE.
- spi_init  out  1  start level to the byte engine.
- spi_addr  out  8  formatted address byte.
- spi_wdata  out  8  data byte to the engine.
- spi_rdata  in  8  byte received by the engine.
- spi_done  in  1  engine completion, sampled high for at least 1 cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - ack=0, rdata=0x00, err=0, busy=0, spi_init=0, spi_addr=0x00, spi_wdata=0x00.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
  - Reset mid-transaction abandons the transaction. No ack is issued. spi_init drops immediately.
- States:
  - IDLE: if any req bit is set, go to ARB. Otherwise stay.
  - ARB:
    - Select the first set req bit, searching from last+1 modulo NREQ.
    - Latch that requester's rw, addr and wdata. Set last to the winner.
    - Build spi_addr: read = {1'b1, addr, 1'b0}; write = {1'b0, addr, 1'b0}.
    - spi_wdata = wdata for a write, 0x00 for a read.
    - Go to ISSUE.
    - If req has cleared by ARB, return to IDLE and leave last unchanged.
  - ISSUE: assert spi_init, go to WAIT.
  - WAIT:
    - Hold spi_init=1, spi_addr and spi_wdata stable.
    - On spi_done=1: drop spi_init, capture rdata = spi_rdata for a read or 0x00 for a write, set err=0, go to RESP.
  - RESP: ack[winner]=1 for exactly one cycle, then go to IDLE.
- Latency: req rising in IDLE gives spi_init high 3 edges later. ack follows spi_done by 1 edge (RESP registered).
- Requester rules:
  - Hold req, rw, addr and wdata stable until ack.
  - Deassert req on the edge at which ack is sampled.
  - A req still high in the IDLE cycle after RESP is a new request.
- Request field changes after ARB are ignored; the latched values are used.
- spi_done outside WAIT is ignored.
- Simultaneous requests: exactly one grant per transaction. With every requester continuously requesting, the order is 0,1,..,NREQ-1,0 (strict rotation).
- rdata and err hold their values until the next RESP.
- At most one ack bit is ever high.

Optional Feature:
- Macro SPI_TIMEOUT_EN.
- Enabled:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without spi_done: drop spi_init, set rdata=0xFF and err=1, go to RESP.
  - If spi_done and the timeout occur in the same cycle, spi_done wins (normal completion, err=0).
- Disabled: WAIT lasts until spi_done, err is tied to 0, and no counter is synthesised.

Test Plan:
- Single read: req[0]=1, rw=1, addr=0x37; engine returns 0x92 five cycles after spi_init -> spi_addr=0xEE, spi_wdata=0x00; ack[0] one cycle; rdata=0x92; err=0.
- Single write: req[1]=1, rw=0, addr=0x01, wdata=0x0F -> spi_addr=0x02, spi_wdata=0x0F; ack[1] pulse; rdata=0x00.
- Contention: req=2'b11 held, each requester re-asserting after its ack -> grant order 0,1,0,1 over 4 transactions; ack never 2'b11.
- Reset mid-WAIT: assert reset=0 with spi_init=1 -> all outputs 0 within the same cycle. After release, req[0] and req[1] both high -> requester 0 granted first.
- Spurious done: pulse spi_done in IDLE -> no ack, state stays IDLE, busy=0.
- Timeout (SPI_TIMEOUT_EN, TIMEOUT_CYCLES=16): engine never returns done -> spi_init drops after 16 WAIT cycles; ack pulse with err=1, rdata=0xFF. Without the macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/rfid_spi_arbiter.sv
// Round-robin transaction arbiter that shares one SPI byte engine between NREQ requesters.
// Optional spi_done watchdog is compiled in with `define SPI_TIMEOUT_EN.
module rfid_spi_arbiter #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_rw,
  input  logic [6*NREQ-1:0]   req_addr,
  input  logic [8*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]     ack,
  output logic [7:0]          rdata,
  output logic                err,
  output logic                busy,
  output logic                spi_init,
  output logic [7:0]          spi_addr,
  output logic [7:0]          spi_wdata,
  input  logic [7:0]          spi_rdata,
  input  logic                spi_done
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("rfid_spi_arbiter: NREQ must be 2..4 and TIMEOUT_CYCLES at least 2");
  end

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] pick;
  logic             pick_rw;
  logic [5:0]       pick_addr;
  logic [7:0]       pick_wdata;
  logic             rw_l;
  logic             timeout;

  // First requester at or after last+1 (mod NREQ); last itself is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] l);
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    win   = l;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(l) + i) % NREQ;
      if (!found && (|(r & (NREQ'(1) << idx)))) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Reader-chip address byte: MSB selects read, LSB is reserved zero.
  function automatic logic [7:0] fmt_addr(input logic rw, input logic [5:0] a);
    return {rw, a, 1'b0};
  endfunction

  assign pick       = rr_pick(req, last);
  assign pick_rw    = |(req_rw & (NREQ'(1) << pick));
  assign pick_addr  = 6'(req_addr >> (6 * int'(pick)));
  assign pick_wdata = 8'(req_wdata >> (8 * int'(pick)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_ARB;
      S_ARB:   state_nxt = (|req) ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (spi_done || timeout) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    ack  = '0;
    if (state == S_RESP) ack = NREQ'(1) << last;
  end

  // Request capture, engine handshake and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last      <= IDX_W'(NREQ - 1);
      rw_l      <= 1'b0;
      spi_addr  <= 8'h00;
      spi_wdata <= 8'h00;
      spi_init  <= 1'b0;
      rdata     <= 8'h00;
    end else begin
      case (state)
        S_ARB: begin
          if (|req) begin
            last      <= pick;
            rw_l      <= pick_rw;
            spi_addr  <= fmt_addr(pick_rw, pick_addr);
            spi_wdata <= pick_rw ? 8'h00 : pick_wdata;
          end
        end
        S_ISSUE: spi_init <= 1'b1;
        S_WAIT: begin
          if (spi_done) begin
            spi_init <= 1'b0;
            rdata    <= rw_l ? spi_rdata : 8'h00;
          end else if (timeout) begin
            spi_init <= 1'b0;
            rdata    <= 8'hFF;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wait_cnt;

  // Counter is zero in the first WAIT cycle; done in the final cycle still wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 wait_cnt <= '0;
    else if (state == S_ISSUE)  wait_cnt <= '0;
    else if (state == S_WAIT)   wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout = (state == S_WAIT) && !spi_done &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (state == S_WAIT) begin
      if (spi_done)     err <= 1'b0;
      else if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_rfid_spi_arbiter.sv
// Directed self-checking bench for rfid_spi_arbiter (NREQ=2, TIMEOUT_CYCLES=16).
module tb_rfid_spi_arbiter;

  localparam int NREQ = 2;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [1:0]    req_rw;
  logic [11:0]   req_addr;
  logic [15:0]   req_wdata;
  logic [1:0]    ack;
  logic [7:0]    rdata;
  logic          err;
  logic          busy;
  logic          spi_init;
  logic [7:0]    spi_addr;
  logic [7:0]    spi_wdata;
  logic [7:0]    spi_rdata;
  logic          spi_done;

  int n_cmp     = 0;
  int n_bad     = 0;
  int ack_multi = 0;

  rfid_spi_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .spi_init(spi_init), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .spi_done(spi_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ack[0] && ack[1]) ack_multi++;

  task automatic set_req(input int i, input logic rw, input logic [5:0] a, input logic [7:0] d);
    req_rw[i]         = rw;
    req_addr[6*i +: 6] = a;
    req_wdata[8*i +: 8] = d;
  endtask

  // Returns at the first negedge where spi_init is high, or after 40 cycles.
  task automatic wait_init(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (spi_init !== 1'b1 && cyc < 40);
  endtask

  // Engine answers after 'delay' WAIT cycles; returns at the RESP-cycle negedge.
  task automatic serve(input logic [7:0] d, input int delay);
    spi_rdata = d;
    repeat (delay) @(negedge clk);
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    spi_rdata = 8'h00; spi_done = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ack !== 2'b00)      begin n_bad++; $display("FAIL rst_ack: got %b want 00", ack); end
    n_cmp++; if (rdata !== 8'h00)    begin n_bad++; $display("FAIL rst_rdata: got %h want 00", rdata); end
    n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (spi_init !== 1'b0)  begin n_bad++; $display("FAIL rst_init: got %b want 0", spi_init); end
    n_cmp++; if (spi_addr !== 8'h00) begin n_bad++; $display("FAIL rst_addr: got %h want 00", spi_addr); end
    n_cmp++; if (spi_wdata !== 8'h00) begin n_bad++; $display("FAIL rst_wdata: got %h want 00", spi_wdata); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_read;
    int cyc;
    set_req(0, 1'b1, 6'h37, 8'hAA);
    req = 2'b01;
    wait_init(cyc);
    n_cmp++; if (cyc !== 3)           begin n_bad++; $display("FAIL rd_latency: got %0d want 3", cyc); end
    n_cmp++; if (spi_addr !== 8'hEE)  begin n_bad++; $display("FAIL rd_spi_addr: got %h want ee", spi_addr); end
    n_cmp++; if (spi_wdata !== 8'h00) begin n_bad++; $display("FAIL rd_spi_wdata: got %h want 00", spi_wdata); end
    n_cmp++; if (busy !== 1'b1)       begin n_bad++; $display("FAIL rd_busy: got %b want 1", busy); end
    serve(8'h92, 5);
    n_cmp++; if (ack !== 2'b01)       begin n_bad++; $display("FAIL rd_ack: got %b want 01", ack); end
    n_cmp++; if (rdata !== 8'h92)     begin n_bad++; $display("FAIL rd_rdata: got %h want 92", rdata); end
    n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL rd_err: got %b want 0", err); end
    n_cmp++; if (spi_init !== 1'b0)   begin n_bad++; $display("FAIL rd_init_drop: got %b want 0", spi_init); end
    n_cmp++; if (spi_addr !== 8'hEE)  begin n_bad++; $display("FAIL rd_addr_hold: got %h want ee", spi_addr); end
    req = 2'b00;
    @(negedge clk);
    n_cmp++; if (ack !== 2'b00)       begin n_bad++; $display("FAIL rd_ack_once: got %b want 00", ack); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rd_idle: got %b want 0", busy); end
    n_cmp++; if (rdata !== 8'h92)     begin n_bad++; $display("FAIL rd_rdata_hold: got %h want 92", rdata); end
  endtask

  task automatic test_single_write;
    int cyc;
    set_req(1, 1'b0, 6'h01, 8'h0F);
    req = 2'b10;
    wait_init(cyc);
    n_cmp++; if (spi_init !== 1'b1)   begin n_bad++; $display("FAIL wr_init: got %b want 1", spi_init); end
    n_cmp++; if (spi_addr !== 8'h02)  begin n_bad++; $display("FAIL wr_spi_addr: got %h want 02", spi_addr); end
    n_cmp++; if (spi_wdata !== 8'h0F) begin n_bad++; $display("FAIL wr_spi_wdata: got %h want 0f", spi_wdata); end
    serve(8'hAB, 2);
    n_cmp++; if (ack !== 2'b10)       begin n_bad++; $display("FAIL wr_ack: got %b want 10", ack); end
    n_cmp++; if (rdata !== 8'h00)     begin n_bad++; $display("FAIL wr_rdata: got %h want 00", rdata); end
    req = 2'b00;
    @(negedge clk);
    n_cmp++; if (ack !== 2'b00)       begin n_bad++; $display("FAIL wr_ack_once: got %b want 00", ack); end
  endtask

  task automatic test_contention;
    int cyc;
    int w;
    logic [7:0] exp_addr;
    logic [7:0] exp_rdata;
    logic [1:0] exp_ack;
    set_req(0, 1'b0, 6'h10, 8'h5A);
    set_req(1, 1'b1, 6'h21, 8'h00);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w         = k % 2;
      exp_addr  = (w == 1) ? 8'hC2 : 8'h20;
      exp_rdata = (w == 1) ? 8'h66 : 8'h00;
      exp_ack   = (w == 1) ? 2'b10 : 2'b01;
      wait_init(cyc);
      n_cmp++; if (spi_addr !== exp_addr) begin n_bad++; $display("FAIL rr_addr[%0d]: got %h want %h", k, spi_addr, exp_addr); end
      serve((w == 1) ? 8'h66 : 8'h99, 1);
      n_cmp++; if (ack !== exp_ack)       begin n_bad++; $display("FAIL rr_ack[%0d]: got %b want %b", k, ack, exp_ack); end
      n_cmp++; if (rdata !== exp_rdata)   begin n_bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, rdata, exp_rdata); end
    end
    req = 2'b00;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_wait;
    int cyc;
    set_req(0, 1'b0, 6'h2A, 8'hC3);
    req = 2'b01;
    wait_init(cyc);
    n_cmp++; if (spi_wdata !== 8'hC3) begin n_bad++; $display("FAIL mid_pre_wdata: got %h want c3", spi_wdata); end
    n_cmp++; if (spi_addr !== 8'h54)  begin n_bad++; $display("FAIL mid_pre_addr: got %h want 54", spi_addr); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (spi_init !== 1'b0)   begin n_bad++; $display("FAIL mid_init: got %b want 0", spi_init); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (ack !== 2'b00)       begin n_bad++; $display("FAIL mid_ack: got %b want 00", ack); end
    n_cmp++; if (spi_addr !== 8'h00)  begin n_bad++; $display("FAIL mid_addr: got %h want 00", spi_addr); end
    n_cmp++; if (spi_wdata !== 8'h00) begin n_bad++; $display("FAIL mid_wdata: got %h want 00", spi_wdata); end
    n_cmp++; if (rdata !== 8'h00)     begin n_bad++; $display("FAIL mid_rdata: got %h want 00", rdata); end
    @(negedge clk);
    reset = 1'b1;
    set_req(0, 1'b1, 6'h05, 8'h00);
    set_req(1, 1'b1, 6'h3F, 8'h00);
    req = 2'b11;
    wait_init(cyc);
    n_cmp++; if (spi_addr !== 8'h8A)  begin n_bad++; $display("FAIL post_rst_grant: got %h want 8a", spi_addr); end
    serve(8'h3C, 0);
    n_cmp++; if (ack !== 2'b01)       begin n_bad++; $display("FAIL post_rst_ack: got %b want 01", ack); end
    n_cmp++; if (rdata !== 8'h3C)     begin n_bad++; $display("FAIL post_rst_rdata: got %h want 3c", rdata); end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_spurious_done;
    spi_rdata = 8'h77;
    spi_done  = 1'b1;
    @(negedge clk);
    spi_done  = 1'b0;
    n_cmp++; if (ack !== 2'b00)   begin n_bad++; $display("FAIL spur_ack: got %b want 00", ack); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL spur_busy: got %b want 0", busy); end
    n_cmp++; if (rdata !== 8'h3C) begin n_bad++; $display("FAIL spur_rdata: got %h want 3c", rdata); end
    @(negedge clk);
    n_cmp++; if (ack !== 2'b00)   begin n_bad++; $display("FAIL spur_ack2: got %b want 00", ack); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL spur_busy2: got %b want 0", busy); end
  endtask

  task automatic test_timeout;
    int cyc;
    int n;
    set_req(1, 1'b1, 6'h11, 8'h00);
    req = 2'b10;
    wait_init(cyc);
`ifdef SPI_TIMEOUT_EN
    n = 0;
    while (spi_init === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_cmp++; if (n !== TO)         begin n_bad++; $display("FAIL to_wait_cycles: got %0d want %0d", n, TO); end
    n_cmp++; if (ack !== 2'b10)    begin n_bad++; $display("FAIL to_ack: got %b want 10", ack); end
    n_cmp++; if (err !== 1'b1)     begin n_bad++; $display("FAIL to_err: got %b want 1", err); end
    n_cmp++; if (rdata !== 8'hFF)  begin n_bad++; $display("FAIL to_rdata: got %h want ff", rdata); end
    req = 2'b00;
    @(negedge clk);
    n_cmp++; if (ack !== 2'b00)    begin n_bad++; $display("FAIL to_ack_once: got %b want 00", ack); end
    n_cmp++; if (err !== 1'b1)     begin n_bad++; $display("FAIL to_err_hold: got %b want 1", err); end
    // spi_done arriving in the last permitted WAIT cycle must beat the timeout.
    req = 2'b10;
    wait_init(cyc);
    serve(8'h5D, TO - 1);
    n_cmp++; if (ack !== 2'b10)    begin n_bad++; $display("FAIL race_ack: got %b want 10", ack); end
    n_cmp++; if (err !== 1'b0)     begin n_bad++; $display("FAIL race_err: got %b want 0", err); end
    n_cmp++; if (rdata !== 8'h5D)  begin n_bad++; $display("FAIL race_rdata: got %h want 5d", rdata); end
    req = 2'b00;
    @(negedge clk);
`else
    n = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy !== 1'b1 || spi_init !== 1'b1 || ack !== 2'b00) n++;
    end
    n_cmp++; if (n !== 0)        begin n_bad++; $display("FAIL no_to_stuck: %0d bad cycles want 0", n); end
    n_cmp++; if (err !== 1'b0)   begin n_bad++; $display("FAIL no_to_err: got %b want 0", err); end
    reset = 1'b0;
    @(negedge clk);
    req   = 2'b00;
    reset = 1'b1;
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_single_write;
    test_contention;
    test_reset_mid_wait;
    test_spurious_done;
    test_timeout;
    n_cmp++; if (ack_multi !== 0) begin n_bad++; $display("FAIL ack_onehot: %0d multi-ack cycles want 0", ack_multi); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
